status_array_ctrl: RTL and testbench
====================================

Name: status_array_ctrl

Overview:
- Sequencer and arbiter in front of the instruction-cache status array.
- After reset it sweeps every status row to zero, so all blocks read as invalid.
- It then shares the array's single command port between two requesters: fill/update writes from the refill path and lookup reads from the fetch path.
- It honours the array's halt/ready and optionally supports a full flush (invalidate-all) sweep.

Parameters:
TAG_WIDTH, 1, width of lookup tag forwarded with a read
ADDR_WIDTH, 4, status array row address width; DEPTH = 2**ADDR_WIDTH = 16
ROW_WIDTH, 8, status row data width
NUM_BLOCKS, 1, write-mask width (one bit per block)

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_halt  in  1  global halt; freezes the controller
i_lk_valid  in  1  lookup read request
i_lk_addr  in  ADDR_WIDTH  lookup row
i_lk_tag  in  TAG_WIDTH  tag forwarded to the array with the read
o_lk_ready  out  1  lookup accepted this cycle when high with i_lk_valid
i_upd_valid  in  1  status write request
i_upd_addr  in  ADDR_WIDTH  write row
i_upd_data  in  ROW_WIDTH  write data
i_upd_wmask  in  NUM_BLOCKS  write mask
o_upd_ready  out  1  update accepted this cycle when high with i_upd_valid
i_flush  in  1  invalidate-all request (see Optional Feature)
i_sa_ready  in  1  status array ready
o_sa_valid  out  1  command valid to the array
o_sa_wen  out  1  1 = write, 0 = read
o_sa_addr  out  ADDR_WIDTH  command row
o_sa_data  out  ROW_WIDTH  write data
o_sa_wmask  out  NUM_BLOCKS  write mask
o_sa_tag  out  TAG_WIDTH  tag for the read
o_init_done  out  1  high when the array contents are valid and requests are being served

Behaviour:
- Clock is clk; reset is arst_n, asynchronous, active-low.
- State is registered; all o_sa_* and ready outputs are combinational from the state and inputs.
- FSM states: RST, SWEEP, RUN. Reset values: state = RST, sweep counter = 0, o_init_done = 0.
- RST: all o_sa_* = 0, both readies = 0. On the first clock edge after reset deasserts, go to SWEEP.
- SWEEP (command outputs):
  - o_sa_valid = 1, o_sa_wen = 1, o_sa_addr = counter, o_sa_data = 0, o_sa_wmask = all ones, o_sa_tag = 0.
  - Both readies = 0.
- SWEEP (advance):
  - The counter increments on each edge where the advance condition holds: i_sa_ready = 1 and i_halt = 0.
  - When counter = DEPTH-1 and the advance condition holds, go to RUN and clear the counter (wraps to 0).
  - Sweep duration is DEPTH advancing cycles; o_init_done rises on the edge that enters RUN.
- RUN arbitration: fixed priority, update over lookup.
  - o_upd_ready = i_sa_ready & ~i_halt.
  - o_lk_ready = i_sa_ready & ~i_halt & ~i_upd_valid.
- RUN, update selected: o_sa_valid = 1, o_sa_wen = 1; address, data and mask come from the upd_* inputs; o_sa_tag = 0.
- RUN, lookup selected (no update pending): o_sa_valid = 1, o_sa_wen = 0, o_sa_addr = i_lk_addr, o_sa_tag = i_lk_tag, o_sa_data = 0, o_sa_wmask = 0.
- RUN, idle: o_sa_valid = 0 and all other o_sa_* = 0.
- Same-address hazard: an update and a lookup to the same row in the same cycle are serialised. The write issues first and the lookup issues next cycle, so it reads the new data. Only one command issues per cycle, so no read-during-write to a row occurs.
- Halt: while i_halt = 1 or i_sa_ready = 0, state and counter hold, both readies are 0, and o_sa_* keep their combinational values (the array's clock is gated).
- Read data returns from the array one cycle after issue; the controller does not track it.
- Reset mid-sweep or mid-run: returns immediately to RST, o_init_done = 0, and the sweep restarts from row 0.

Optional Feature:
- Macro: STATUS_ARRAY_CTRL_FLUSH_EN.
- Defined:
  - i_flush = 1 sampled in RUN on an advancing edge moves the FSM to SWEEP with the counter at 0; o_init_done falls on that edge.
  - A request accepted in the same cycle as the flush still completes.
  - i_flush during RST or SWEEP is ignored; the sweep is not restarted.
- Not defined: i_flush is ignored in all states and the controller never re-enters SWEEP after initialisation.

Test Plan:
- Release reset with i_sa_ready = 1 and no requests -> one RST cycle, then 16 consecutive writes to addr 0..15 with data 0x00 and wmask 1; o_init_done = 1 after the 16th write.
- Drop i_sa_ready for 3 cycles during the sweep at addr 5 -> addr 5 is held for those 3 cycles, then resumes at 6; total sweep is 19 cycles.
- In RUN, assert update (addr 3, data 0xA5) and lookup (addr 3, tag 1) together -> cycle N: write addr 3 with 0xA5 and o_lk_ready = 0; cycle N+1: read addr 3 with o_sa_tag = 1.
- Hold i_halt = 1 for 4 cycles with a lookup pending -> both readies = 0 and the state is frozen; the lookup issues in the cycle after the halt drops.
- With STATUS_ARRAY_CTRL_FLUSH_EN defined, pulse i_flush in RUN -> o_init_done drops next edge and a 16-write zero sweep follows. Without the macro, the same pulse produces no sweep and o_init_done stays 1.
- Assert arst_n low at sweep addr 9 -> outputs return to their reset values immediately; after release the sweep restarts at addr 0.

Source files
------------

// File: rtl/status_array_ctrl.sv
// status_array_ctrl: sequencer/arbiter for the instruction-cache status array.
// After reset it zeroes every row, then shares the single array command port
// between refill updates (priority) and fetch lookups.
// Optional feature macro: STATUS_ARRAY_CTRL_FLUSH_EN (invalidate-all sweep in RUN).
module status_array_ctrl #(
  parameter int unsigned TAG_WIDTH  = 1,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned ROW_WIDTH  = 8,
  parameter int unsigned NUM_BLOCKS = 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic                  i_lk_valid,
  input  logic [ADDR_WIDTH-1:0] i_lk_addr,
  input  logic [TAG_WIDTH-1:0]  i_lk_tag,
  output logic                  o_lk_ready,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_addr,
  input  logic [ROW_WIDTH-1:0]  i_upd_data,
  input  logic [NUM_BLOCKS-1:0] i_upd_wmask,
  output logic                  o_upd_ready,
  input  logic                  i_flush,
  input  logic                  i_sa_ready,
  output logic                  o_sa_valid,
  output logic                  o_sa_wen,
  output logic [ADDR_WIDTH-1:0] o_sa_addr,
  output logic [ROW_WIDTH-1:0]  o_sa_data,
  output logic [NUM_BLOCKS-1:0] o_sa_wmask,
  output logic [TAG_WIDTH-1:0]  o_sa_tag,
  output logic                  o_init_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_SWEEP = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    init_done_q, init_done_d;
  logic                    advance;
  logic                    flush_req;

  // The array only consumes a command when it is ready and we are not halted.
  assign advance = i_sa_ready & ~i_halt;

`ifdef STATUS_ARRAY_CTRL_FLUSH_EN
  assign flush_req = i_flush;
`else
  logic unused_flush;
  assign unused_flush = i_flush;
  assign flush_req    = 1'b0;
`endif

  // Next-state, sweep counter and init flag.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_RST: begin
        state_d = ST_SWEEP;
        cnt_d   = '0;
      end
      ST_SWEEP: begin
        if (advance) begin
          if (cnt_q == LAST_ROW) begin
            state_d     = ST_RUN;
            cnt_d       = '0;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1'b1);
          end
        end
      end
      ST_RUN: begin
        if (advance && flush_req) begin
          state_d     = ST_SWEEP;
          cnt_d       = '0;
          init_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_RST;
        cnt_d       = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State, counter and init flag registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_RST;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign o_init_done = init_done_q;

  // Array command and requester handshakes; update wins over lookup.
  always_comb begin
    o_sa_valid  = 1'b0;
    o_sa_wen    = 1'b0;
    o_sa_addr   = '0;
    o_sa_data   = '0;
    o_sa_wmask  = '0;
    o_sa_tag    = '0;
    o_upd_ready = 1'b0;
    o_lk_ready  = 1'b0;
    unique case (state_q)
      ST_SWEEP: begin
        o_sa_valid = 1'b1;
        o_sa_wen   = 1'b1;
        o_sa_addr  = cnt_q;
        o_sa_wmask = '1;
      end
      ST_RUN: begin
        o_upd_ready = advance;
        o_lk_ready  = advance & ~i_upd_valid;
        if (i_upd_valid) begin
          o_sa_valid = 1'b1;
          o_sa_wen   = 1'b1;
          o_sa_addr  = i_upd_addr;
          o_sa_data  = i_upd_data;
          o_sa_wmask = i_upd_wmask;
        end else if (i_lk_valid) begin
          o_sa_valid = 1'b1;
          o_sa_addr  = i_lk_addr;
          o_sa_tag   = i_lk_tag;
        end
      end
      default: begin
        o_sa_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_status_array_ctrl.sv
// Self-checking bench for status_array_ctrl with a behavioural reference model.
module tb_status_array_ctrl;

`ifdef STATUS_ARRAY_CTRL_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  localparam int P_RST = 0, P_SWEEP = 1, P_RUN = 2;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       i_halt, i_lk_valid, i_upd_valid, i_flush, i_sa_ready;
  logic [3:0] i_lk_addr, i_upd_addr;
  logic [0:0] i_lk_tag, i_upd_wmask;
  logic [7:0] i_upd_data;
  logic       o_lk_ready, o_upd_ready, o_sa_valid, o_sa_wen, o_init_done;
  logic [3:0] o_sa_addr;
  logic [7:0] o_sa_data;
  logic [0:0] o_sa_wmask, o_sa_tag;

  int errors = 0;
  int checks = 0;

  // Reference model: phase of operation, next row to clear, init flag.
  int m_phase;
  int m_row;
  bit m_done;

  logic [18:0] obs;
  assign obs = {o_sa_valid, o_sa_wen, o_sa_addr, o_sa_data, o_sa_wmask, o_sa_tag,
                o_upd_ready, o_lk_ready, o_init_done};

  status_array_ctrl dut (
    .clk(clk), .arst_n(arst_n), .i_halt(i_halt),
    .i_lk_valid(i_lk_valid), .i_lk_addr(i_lk_addr), .i_lk_tag(i_lk_tag), .o_lk_ready(o_lk_ready),
    .i_upd_valid(i_upd_valid), .i_upd_addr(i_upd_addr), .i_upd_data(i_upd_data),
    .i_upd_wmask(i_upd_wmask), .o_upd_ready(o_upd_ready),
    .i_flush(i_flush), .i_sa_ready(i_sa_ready),
    .o_sa_valid(o_sa_valid), .o_sa_wen(o_sa_wen), .o_sa_addr(o_sa_addr), .o_sa_data(o_sa_data),
    .o_sa_wmask(o_sa_wmask), .o_sa_tag(o_sa_tag), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  // Expected outputs for the current model phase and current inputs.
  function automatic logic [18:0] expv();
    logic v, w, m, t, ur, lr;
    logic [3:0] a;
    logic [7:0] d;
    {v, w, a, d, m, t, ur, lr} = '0;
    if (m_phase == P_SWEEP) begin
      v = 1; w = 1; a = 4'(m_row); m = 1;
    end else if (m_phase == P_RUN) begin
      ur = i_sa_ready && !i_halt;
      lr = ur && !i_upd_valid;
      if (i_upd_valid) begin
        v = 1; w = 1; a = i_upd_addr; d = i_upd_data; m = i_upd_wmask[0];
      end else if (i_lk_valid) begin
        a = i_lk_addr; v = 1; t = i_lk_tag[0];
      end
    end
    return {v, w, a, d, m, t, ur, lr, m_done};
  endfunction

  // Advance model across one rising edge, then return to the falling edge.
  task automatic step();
    bit adv;
    @(posedge clk);
    adv = i_sa_ready && !i_halt;
    if (!arst_n) begin
      m_phase = P_RST; m_row = 0; m_done = 0;
    end else if (m_phase == P_RST) begin
      m_phase = P_SWEEP; m_row = 0;
    end else if (m_phase == P_SWEEP && adv) begin
      if (m_row == 15) begin m_phase = P_RUN; m_row = 0; m_done = 1; end
      else m_row = m_row + 1;
    end else if (m_phase == P_RUN && adv && FLUSH_EN && i_flush) begin
      m_phase = P_SWEEP; m_row = 0; m_done = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_halt = 0; i_lk_valid = 0; i_upd_valid = 0; i_flush = 0; i_sa_ready = 1;
    i_lk_addr = 0; i_upd_addr = 0; i_lk_tag = 0; i_upd_wmask = 0; i_upd_data = 0;
  endtask

  task automatic assert_reset();
    arst_n = 0;
    m_phase = P_RST; m_row = 0; m_done = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    assert_reset();
    @(negedge clk);
    #1;
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL reset_outputs obs=%h exp=%h", obs, 19'h0); end
    step();
    arst_n = 1;
    #1;
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL rst_cycle obs=%h exp=%h", obs, expv()); end
    step();
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (obs !== expv() || o_sa_addr !== 4'(i) || o_sa_wen !== 1'b1 || o_sa_data !== 8'h00) begin
        errors++; $display("FAIL sweep_row%0d obs=%h exp=%h", i, obs, expv());
      end
      step();
    end
    #1;
    checks++;
    if (o_init_done !== 1'b1 || o_sa_valid !== 1'b0) begin
      errors++; $display("FAIL init_done_after_sweep done=%b valid=%b exp done=1 valid=0", o_init_done, o_sa_valid);
    end
  endtask

  task automatic test_sweep_stall();
    int cycles = 0;
    int stalls = 0;
    logic [3:0] q[$];
    assert_reset();
    step();
    arst_n = 1;
    step();
    for (int c = 0; c < 40 && m_phase != P_RUN; c++) begin
      i_sa_ready = !(m_row == 5 && stalls < 3);
      if (!i_sa_ready) stalls++;
      #1;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL stall_sweep_cyc%0d obs=%h exp=%h", c, obs, expv()); end
      if (o_sa_valid && o_sa_wen && i_sa_ready) q.push_back(o_sa_addr);
      cycles++;
      step();
    end
    i_sa_ready = 1;
    #1;
    checks++;
    if (cycles != 19 || o_init_done !== 1'b1) begin
      errors++; $display("FAIL stall_sweep_len cycles=%0d done=%b exp 19 1", cycles, o_init_done);
    end
    checks++;
    if (q.size() != 16) begin
      errors++; $display("FAIL stall_sweep_writes got=%0d exp=16", q.size());
    end else begin
      for (int i = 0; i < 16; i++)
        if (q[i] !== 4'(i)) begin
          errors++; $display("FAIL stall_sweep_order idx=%0d got=%0d exp=%0d", i, q[i], i);
        end
    end
  endtask

  task automatic test_reset_mid_sweep();
    assert_reset();
    step();
    arst_n = 1;
    step();
    for (int c = 0; c < 30 && !(m_phase == P_SWEEP && m_row == 9); c++) step();
    #1;
    checks++;
    if (o_sa_addr !== 4'd9) begin errors++; $display("FAIL pre_reset_addr got=%0d exp=9", o_sa_addr); end
    assert_reset();
    #1;
    checks++;
    if (obs !== 19'h0) begin errors++; $display("FAIL mid_sweep_reset obs=%h exp=%h", obs, 19'h0); end
    step();
    arst_n = 1;
    step();
    #1;
    checks++;
    if (obs !== expv() || o_sa_addr !== 4'd0 || o_sa_valid !== 1'b1) begin
      errors++; $display("FAIL sweep_restart obs=%h exp=%h", obs, expv());
    end
    for (int c = 0; c < 30 && m_phase != P_RUN; c++) step();
    #1;
    checks++;
    if (o_init_done !== 1'b1) begin errors++; $display("FAIL restart_done got=%b exp=1", o_init_done); end
  endtask

  task automatic test_hazard();
    i_upd_valid = 1; i_upd_addr = 3; i_upd_data = 8'hA5; i_upd_wmask = 1;
    i_lk_valid = 1; i_lk_addr = 3; i_lk_tag = 1;
    #1;
    checks++;
    if (obs !== expv() || o_sa_wen !== 1'b1 || o_sa_addr !== 4'd3 || o_sa_data !== 8'hA5 ||
        o_lk_ready !== 1'b0 || o_upd_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_write obs=%h exp=%h", obs, expv());
    end
    step();
    i_upd_valid = 0;
    #1;
    checks++;
    if (obs !== expv() || o_sa_wen !== 1'b0 || o_sa_addr !== 4'd3 || o_sa_tag !== 1'b1 ||
        o_lk_ready !== 1'b1) begin
      errors++; $display("FAIL hazard_read obs=%h exp=%h", obs, expv());
    end
    step();
    i_lk_valid = 0;
  endtask

  task automatic test_halt();
    i_lk_valid = 1; i_lk_addr = 4'hC; i_lk_tag = 0;
    i_halt = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (obs !== expv() || o_lk_ready !== 1'b0 || o_upd_ready !== 1'b0 || o_init_done !== 1'b1) begin
        errors++; $display("FAIL halt_cyc%0d obs=%h exp=%h", c, obs, expv());
      end
      step();
    end
    i_halt = 0;
    #1;
    checks++;
    if (obs !== expv() || o_lk_ready !== 1'b1 || o_sa_addr !== 4'hC || o_sa_valid !== 1'b1) begin
      errors++; $display("FAIL halt_release obs=%h exp=%h", obs, expv());
    end
    step();
    i_lk_valid = 0;
  endtask

  task automatic test_flush();
    int writes = 0;
    bit nonzero = 0;
    i_flush = 1;
    #1;
    checks++;
    if (obs !== expv()) begin errors++; $display("FAIL flush_cycle obs=%h exp=%h", obs, expv()); end
    step();
    i_flush = 0;
    #1;
    checks++;
    if (o_init_done !== !FLUSH_EN) begin
      errors++; $display("FAIL flush_done got=%b exp=%b", o_init_done, !FLUSH_EN);
    end
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL flush_seq_cyc%0d obs=%h exp=%h", c, obs, expv()); end
      if (o_sa_valid && o_sa_wen) begin
        if (o_sa_addr !== 4'(writes) || o_sa_data !== 8'h00) nonzero = 1;
        writes++;
      end
      step();
    end
    #1;
    checks++;
    if (writes != (FLUSH_EN ? 16 : 0) || nonzero || o_init_done !== 1'b1) begin
      errors++; $display("FAIL flush_sweep writes=%0d exp=%0d bad=%b done=%b", writes, FLUSH_EN ? 16 : 0, nonzero, o_init_done);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      i_halt      = ($urandom_range(0, 4) == 0);
      i_sa_ready  = ($urandom_range(0, 4) != 0);
      i_upd_valid = $urandom_range(0, 1) == 1;
      i_lk_valid  = $urandom_range(0, 1) == 1;
      i_flush     = ($urandom_range(0, 31) == 0);
      i_upd_addr  = 4'($urandom);
      i_lk_addr   = 4'($urandom);
      i_upd_data  = 8'($urandom);
      i_upd_wmask = 1'($urandom);
      i_lk_tag    = 1'($urandom);
      #1;
      checks++;
      if (obs !== expv()) begin errors++; $display("FAIL random_cyc%0d obs=%h exp=%h", c, obs, expv()); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    arst_n = 0;
    idle_inputs();
    m_phase = P_RST; m_row = 0; m_done = 0;
    test_reset();
    test_sweep_stall();
    test_reset_mid_sweep();
    test_hazard();
    test_halt();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
